// File: rtl/cordic_hyp_unit_if.sv
// Request/response handshake bundle for the hyperbolic CORDIC unit.
interface cordic_hyp_unit_if #(
    parameter int WIDTH = 20,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_angle;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [TAG_W-1:0] out_tag;
    logic             out_range_err;

    modport master (
        output in_valid, in_op, in_angle, in_tag, out_ready,
        input  in_ready, out_valid, out_value, out_tag, out_range_err
    );

    modport slave (
        input  in_valid, in_op, in_angle, in_tag, out_ready,
        output in_ready, out_valid, out_value, out_tag, out_range_err
    );
endinterface

// File: rtl/cordic_hyp_unit.sv
// Iterative hyperbolic CORDIC: tanh/sinh/cosh/exp of a signed Q(WIDTH-FRAC).FRAC argument.
// Hyperbolic rotation produces cosh/sinh; tanh adds a linear vectoring pass (sinh/cosh).
module cordic_hyp_unit #(
    parameter int WIDTH = 20,
    parameter int FRAC  = 16,
    parameter int ITER  = 16,
    parameter int GUARD = 3,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    cordic_hyp_unit_if.slave bus
);
    localparam int IW = WIDTH + GUARD;
    localparam int IF = FRAC + GUARD;
    localparam int H  = ITER + 2;
    localparam int CW = $clog2(H + 1);

    // 1/K_h and the clamp limit, both as Q2.30 constants.
    localparam logic [63:0] INV_KH_Q30 = 64'd1296540104;
    localparam logic [63:0] ZMAX_Q30   = 64'd1200570368;

    typedef enum logic [1:0] {IDLE, HYP, LIN, DONE} state_t;
    typedef enum logic [1:0] {OP_TANH = 2'd0, OP_SINH = 2'd1, OP_COSH = 2'd2, OP_EXP = 2'd3} op_t;
    typedef logic [IW-1:0] atanh_tab_t [32];

    function automatic logic [63:0] q30_round(input logic [63:0] v, input int fb);
        logic [63:0] r;
        if (fb >= 30) r = v << (fb - 30);
        else          r = (v + (64'd1 << (29 - fb))) >> (30 - fb);
        return r;
    endfunction

    function automatic logic [63:0] atanh_q30(input int unsigned i);
        logic [63:0] r;
        case (i)
            1:  r = 64'd589812981;
            2:  r = 64'd274247418;
            3:  r = 64'd134923406;
            4:  r = 64'd67196451;
            5:  r = 64'd33565361;
            6:  r = 64'd16778582;
            7:  r = 64'd8388779;
            8:  r = 64'd4194325;
            9:  r = 64'd2097155;
            10: r = 64'd1048576;
            11: r = 64'd524288;
            12: r = 64'd262144;
            13: r = 64'd131072;
            14: r = 64'd65536;
            15: r = 64'd32768;
            16: r = 64'd16384;
            17: r = 64'd8192;
            18: r = 64'd4096;
            19: r = 64'd2048;
            20: r = 64'd1024;
            21: r = 64'd512;
            22: r = 64'd256;
            23: r = 64'd128;
            24: r = 64'd64;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic atanh_tab_t build_atanh_tab();
        atanh_tab_t tab;
        for (int unsigned i = 0; i < 32; i++) tab[i] = IW'(q30_round(atanh_q30(i), IF));
        return tab;
    endfunction

    localparam atanh_tab_t ATANH_TAB = build_atanh_tab();

    localparam logic signed [IW-1:0]    X0      = IW'(q30_round(INV_KH_Q30, IF));
    localparam logic signed [IW-1:0]    ONE_I   = IW'(64'd1 << IF);
    localparam logic signed [WIDTH-1:0] ZMAX    = WIDTH'(q30_round(ZMAX_Q30, FRAC));
    localparam logic signed [WIDTH-1:0] ZMIN    = -ZMAX;
    localparam logic signed [IW+1:0]    RND     = (IW+2)'(GUARD > 0 ? (64'd1 << (GUARD - 1)) : 64'd0);
    localparam logic signed [IW+1:0]    RES_MAX = (IW+2)'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic signed [IW+1:0]    RES_MIN = -RES_MAX - (IW+2)'(1);
    localparam logic [CW-1:0]           CNT_H    = CW'(H);
    localparam logic [CW-1:0]           CNT_HL   = CW'(H - 1);
    localparam logic [CW-1:0]           CNT_LIN  = CW'(ITER);

    // Hyperbolic step k -> shift i: 1,2,3,4,4,5,...,13,13,14,...,ITER
    function automatic logic [4:0] hyp_shift(input logic [CW-1:0] k);
        int unsigned kk;
        kk = 32'(k);
        if (kk < 4)        return 5'(kk + 1);
        else if (kk == 14) return 5'd13;
        else if (kk < 14)  return 5'(kk);
        else               return 5'(kk - 1);
    endfunction

    // Drop guard bits with round-half-up, then saturate to WIDTH.
    function automatic logic [WIDTH-1:0] fmt_result(input logic signed [IW:0] v);
        logic signed [IW+1:0] r;
        r = ((IW+2)'(v) + RND) >>> GUARD;
        if (r > RES_MAX)      return RES_MAX[WIDTH-1:0];
        else if (r < RES_MIN) return RES_MIN[WIDTH-1:0];
        return r[WIDTH-1:0];
    endfunction

    state_t               state;
    op_t                  op_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 err_q;
    logic [CW-1:0]        cnt;
    logic signed [IW-1:0] x, y, z;

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_value_q;
    logic [TAG_W-1:0]     out_tag_q;
    logic                 out_err_q;

    logic [4:0]             sh;
    logic signed [IW-1:0]   x_sh, y_sh, atanh_i, pow_i;
    logic signed [IW-1:0]   hx_n, hy_n, hz_n, ly_n, lz_n;
    logic signed [IW:0]     hyp_res;
    logic signed [WIDTH-1:0] ang, z_clamp;
    logic signed [IW-1:0]   z_init;
    logic                   clamp_hit;

    // Micro-step for the active phase, result selection and argument clamp.
    always_comb begin
        sh      = (state == LIN) ? 5'(cnt) : hyp_shift(cnt);
        x_sh    = x >>> sh;
        y_sh    = y >>> sh;
        atanh_i = ATANH_TAB[sh];
        pow_i   = ONE_I >>> sh;

        if (!z[IW-1]) begin
            hx_n = x + y_sh;
            hy_n = y + x_sh;
            hz_n = z - atanh_i;
        end else begin
            hx_n = x - y_sh;
            hy_n = y - x_sh;
            hz_n = z + atanh_i;
        end

        if (!y[IW-1]) begin
            ly_n = y - x_sh;
            lz_n = z + pow_i;
        end else begin
            ly_n = y + x_sh;
            lz_n = z - pow_i;
        end

        case (op_q)
            OP_SINH: hyp_res = {y[IW-1], y};
            OP_COSH: hyp_res = {x[IW-1], x};
            default: hyp_res = {x[IW-1], x} + {y[IW-1], y};
        endcase

        ang       = bus.in_angle;
        z_clamp   = ang;
        clamp_hit = 1'b0;
        if (ang > ZMAX) begin
            z_clamp   = ZMAX;
            clamp_hit = 1'b1;
        end else if (ang < ZMIN) begin
            z_clamp   = ZMIN;
            clamp_hit = 1'b1;
        end
        z_init = IW'(z_clamp) <<< GUARD;
    end

    // Control FSM and datapath registers; HYP spends one extra count (cnt==H)
    // forming the result for non-tanh ops, while tanh hands off to LIN on its
    // last rotation step so both paths end with a single formatting cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_TANH;
            tag_q       <= '0;
            err_q       <= 1'b0;
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= op_t'(bus.in_op);
                        tag_q      <= bus.in_tag;
                        err_q      <= clamp_hit;
                        x          <= X0;
                        y          <= '0;
                        z          <= z_init;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= HYP;
                    end
                end
                HYP: begin
                    if (cnt == CNT_H) begin
                        out_value_q <= fmt_result(hyp_res);
                        out_tag_q   <= tag_q;
                        out_err_q   <= err_q;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        x   <= hx_n;
                        y   <= hy_n;
                        z   <= hz_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_HL && op_q == OP_TANH) begin
                            z     <= '0;
                            cnt   <= '0;
                            state <= LIN;
                        end
                    end
                end
                LIN: begin
                    if (cnt == CNT_LIN) begin
                        out_value_q <= fmt_result({z[IW-1], z});
                        out_tag_q   <= tag_q;
                        out_err_q   <= err_q;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        y   <= ly_n;
                        z   <= lz_n;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_value     = out_value_q;
    assign bus.out_tag       = out_tag_q;
    assign bus.out_range_err = out_err_q;
endmodule

// File: tb/tb_cordic_hyp_unit.sv
// Self-checking bench for cordic_hyp_unit: vector table plus scoreboard, reset and back-pressure sequences.
module tb_cordic_hyp_unit;
    localparam int WIDTH = 20;
    localparam int TAG_W = 4;
    localparam int TOL   = 8;

    typedef struct {
        logic [1:0]       op;
        int               angle;
        logic [TAG_W-1:0] tag;
        int               value;
        bit               err;
        int               lat;
    } vec_t;

    typedef struct {
        int               value;
        logic [TAG_W-1:0] tag;
        bit               err;
        int               lat;
        longint           acc;
    } exp_t;

    logic   clk;
    logic   reset;
    longint cyc;
    int     n_vec;
    int     n_err;
    exp_t   sb[$];
    bit     ov_prev;

    cordic_hyp_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    cordic_hyp_unit #(
        .WIDTH(WIDTH),
        .FRAC (16),
        .ITER (16),
        .GUARD(3),
        .TAG_W(TAG_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req, input longint tol);
        n_vec++;
        if (act > req + tol || act < req - tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, req, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: latency on out_valid rise, values on each transfer.
    always @(negedge clk) begin
        if (reset) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.out_valid && !ov_prev) begin
                if (sb.size() == 0) check("spurious_out_valid", 1, 0, 0);
                else check($sformatf("latency_tag%0d", sb[0].tag), cyc - sb[0].acc, sb[0].lat, 0);
            end
            if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("value_tag%0d", e.tag), longint'($signed(bus.out_value)), e.value, TOL);
                check($sformatf("tag_tag%0d", e.tag), bus.out_tag, e.tag, 0);
                check($sformatf("range_err_tag%0d", e.tag), bus.out_range_err, e.err, 0);
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.value = v.value;
        e.tag   = v.tag;
        e.err   = v.err;
        e.lat   = v.lat;
        e.acc   = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        logic [31:0] a;
        a = v.angle;
        bus.in_valid = 1'b1;
        bus.in_op    = v.op;
        bus.in_angle = a[WIDTH-1:0];
        bus.in_tag   = v.tag;
    endtask

    task automatic send(input vec_t v);
        int unsigned w;
        drive(v);
        w = 0;
        while (!bus.in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!bus.in_ready) check("accept_timeout", 0, 1, 0);
        else push_exp(v);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int unsigned w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        check("result_timeout", sb.size(), 0, 0);
        tick();
    endtask

    vec_t vecs[16];
    vec_t bp_a, bp_b;

    initial begin
        n_vec = 0;
        n_err = 0;
        ov_prev = 1'b0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_angle  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        //           op     angle    tag    value   err lat
        vecs[0]  = '{2'd0,  32768,  4'd5,   30285, 1'b0, 35};
        vecs[1]  = '{2'd1,  32768,  4'd1,   34150, 1'b0, 19};
        vecs[2]  = '{2'd2,  32768,  4'd2,   73900, 1'b0, 19};
        vecs[3]  = '{2'd3,  65536,  4'd3,  178145, 1'b0, 19};
        vecs[4]  = '{2'd0, -65536,  4'd4,  -49912, 1'b0, 35};
        vecs[5]  = '{2'd2,      0,  4'd6,   65536, 1'b0, 19};
        vecs[6]  = '{2'd0, 131072,  4'd7,   52874, 1'b1, 35};
        vecs[7]  = '{2'd1, -32768,  4'd8,  -34150, 1'b0, 19};
        vecs[8]  = '{2'd3, -65536,  4'd9,   24109, 1'b0, 19};
        vecs[9]  = '{2'd0,      0,  4'd10,      0, 1'b0, 35};
        vecs[10] = '{2'd3,      0,  4'd11,  65536, 1'b0, 19};
        vecs[11] = '{2'd0,-131072,  4'd12, -52874, 1'b1, 35};
        vecs[12] = '{2'd2,  65536,  4'd13, 101127, 1'b0, 19};
        vecs[13] = '{2'd0,  16384,  4'd14,  16051, 1'b0, 35};
        vecs[14] = '{2'd1,  65536,  4'd15,  77018, 1'b0, 19};
        vecs[15] = '{2'd3,  32768,  4'd0,  108050, 1'b0, 19};

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_in_ready", bus.in_ready, 1, 0);
        check("reset_out_valid", bus.out_valid, 0, 0);
        check("reset_out_value", bus.out_value, 0, 0);
        check("reset_out_tag", bus.out_tag, 0, 0);
        check("reset_out_range_err", bus.out_range_err, 0, 0);

        for (int i = 0; i < 16; i++) begin
            send(vecs[i]);
            wait_empty();
        end

        // Reset in the middle of the hyperbolic phase abandons the request.
        send(vecs[0]);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        check("midreset_out_valid", bus.out_valid, 0, 0);
        check("midreset_out_value", bus.out_value, 0, 0);
        check("midreset_in_ready", bus.in_ready, 1, 0);
        sb.delete();
        tick();
        reset = 1'b0;
        repeat (60) tick();
        check("postreset_no_output", bus.out_valid, 0, 0);

        // Back-pressure: result held for 10 cycles with a second request waiting.
        bp_a = '{2'd2, 32768, 4'd3, 73900, 1'b0, 19};
        bp_b = '{2'd1,     0, 4'd9,     0, 1'b0, 19};
        bus.out_ready = 1'b0;
        drive(bp_a);
        if (!bus.in_ready) check("bp_accept", bus.in_ready, 1, 0);
        else push_exp(bp_a);
        tick();
        drive(bp_b);
        for (int w = 0; w < 100 && !bus.out_valid; w++) tick();
        check("bp_out_valid", bus.out_valid, 1, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_valid", bus.out_valid, 1, 0);
            check("bp_hold_value", longint'($signed(bus.out_value)), 73900, TOL);
            check("bp_hold_tag", bus.out_tag, 3, 0);
            check("bp_hold_in_ready", bus.in_ready, 0, 0);
            check("bp_hold_queue", sb.size(), 1, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", bus.out_valid, 0, 0);
        check("bp_release_in_ready", bus.in_ready, 1, 0);
        check("bp_single_transfer", sb.size(), 0, 0);
        if (bus.in_ready) push_exp(bp_b);
        tick();
        bus.in_valid = 1'b0;
        check("bp_second_accepted", bus.in_ready, 0, 0);
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
